mult_8_bit_seq: RTL and testbench

- Sequential 8x8 unsigned shift-and-add multiplier controller.
- Time-shares one existing full_adder_8_bit instance over 8 iterations and produces a 16-bit product.
- Sits above the adder as its sequencer, with a start/busy/done handshake toward the requesting logic.

---
 rtl/mult_8_bit_seq_pkg.sv | 15 +
 rtl/full_adder_8_bit.sv | 17 +
 rtl/mult_8_bit_seq.sv | 116 +++++++++++
 tb/tb_mult_8_bit_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mult_8_bit_seq_pkg.sv
// Shared definitions for the sequential 8x8 multiplier.
// State encoding and iteration count used by the controller.
package mult_8_bit_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MULT_ITER = 8;

    localparam logic [3:0] LAST_CNT = 4'(MULT_ITER - 1);

endpackage

// File: rtl/full_adder_8_bit.sv
// Existing 8-bit ripple adder block.
// Produces an 8-bit sum and a carry-out.
module full_adder_8_bit (
    output logic [7:0] s,
    output logic       cout,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin
);

    logic [8:0] total;

    assign total   = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    assign s       = total[7:0];
    assign cout    = total[8];

endmodule

// File: rtl/mult_8_bit_seq.sv
// Shift-and-add 8x8 unsigned multiplier.
// Reuses one full_adder_8_bit across eight iterations.
module mult_8_bit_seq
    import mult_8_bit_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    state_t      state;
    state_t      state_nx;

    logic [7:0]  m;
    logic [7:0]  acc_hi;
    logic [7:0]  acc_lo;
    logic [3:0]  cnt;

    logic        load;
    logic        step;
    logic        last;

    logic [7:0]  addend;
    logic [7:0]  sum;
    logic        cout;
    logic [15:0] shifted;

    assign addend  = acc_lo[0] ? m : 8'd0;

    full_adder_8_bit u_add (
        .s    (sum),
        .cout (cout),
        .a    (acc_hi),
        .b    (addend),
        .cin  (1'b0)
    );

    // Carry is kept: acc_hi + m can reach 510.
    assign shifted = {cout, sum, acc_lo[7:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        last     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST_CNT) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                // The closing edge of DONE may accept a new request.
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m      <= 8'd0;
            acc_hi <= 8'd0;
            acc_lo <= 8'd0;
            cnt    <= 4'd0;
        end else if (load) begin
            m      <= a;
            acc_hi <= 8'd0;
            acc_lo <= b;
            cnt    <= 4'd0;
        end else if (step) begin
            {acc_hi, acc_lo} <= shifted;
            cnt              <= cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            product <= 16'd0;
        end else if (last) begin
            product <= shifted;
        end
    end

    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mult_8_bit_seq.sv
// Randomized scoreboard bench for mult_8_bit_seq.
// Expected products come from plain a*b arithmetic.
module tb_mult_8_bit_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int errors;
    int checks;

    int unsigned exp_q[$];

    mult_8_bit_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act,
                       input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got product %0d expected none",
                         product);
            end else begin
                chk("product", product, exp_q.pop_front());
            end
        end
    end

    // Called at a negedge. Runs one operation through E0..E9, checking
    // busy/done each cycle. ig1/ig2: cycle indices after which a stray
    // start is driven. chain: issue the next request during DONE.
    task automatic op(input logic [7:0] x, input logic [7:0] y,
                      input bit issued, input int ig1, input int ig2,
                      input bit chain, input logic [7:0] nx,
                      input logic [7:0] ny, output bit chained);
        chained = 1'b0;
        if (!issued) begin
            start = 1'b1;
            a     = x;
            b     = y;
            exp_q.push_back(int'(x) * int'(y));
        end
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            chk($sformatf("busy_k%0d", k), busy, (k <= 8) ? 1 : 0);
            chk($sformatf("done_k%0d", k), done, (k == 8) ? 1 : 0);
            start = 1'b0;
            a     = 8'($urandom);
            b     = 8'($urandom);
            if (k == ig1 || k == ig2) begin
                start = 1'b1;
                a     = 8'd17;
                b     = 8'd28;
            end
            if (k == 8 && chain) begin
                start = 1'b1;
                a     = nx;
                b     = ny;
                exp_q.push_back(int'(nx) * int'(ny));
                chained = 1'b1;
                return;
            end
        end
        start = 1'b0;
    endtask

    task automatic simple(input logic [7:0] x, input logic [7:0] y);
        bit c;
        op(x, y, 1'b0, -1, -1, 1'b0, 8'd0, 8'd0, c);
    endtask

    initial begin
        bit c;
        logic [7:0] rx;
        logic [7:0] ry;
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        start  = 1'b0;
        a      = 8'd0;
        b      = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_product", product, 0);
        reset = 1'b0;
        @(negedge clk);

        simple(8'd29, 8'd5);
        simple(8'd255, 8'd255);
        simple(8'd200, 8'd95);
        simple(8'd0, 8'd200);
        simple(8'd78, 8'd0);

        // Stray starts sampled at E3 and E8 must be ignored.
        op(8'd51, 8'd92, 1'b0, 2, 7, 1'b0, 8'd0, 8'd0, c);
        repeat (4) @(negedge clk);
        chk("held_product", product, 4692);
        chk("held_busy", busy, 0);

        // Reset sampled at E4 of 43*59 aborts it.
        start = 1'b1;
        a     = 8'd43;
        b     = 8'd59;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_product", product, 0);
        reset = 1'b0;
        simple(8'd17, 8'd28);

        // Back-to-back: 191*2 accepted at the edge closing DONE.
        op(8'd9, 8'd10, 1'b0, -1, -1, 1'b1, 8'd191, 8'd2, c);
        op(8'd191, 8'd2, c, -1, -1, 1'b0, 8'd0, 8'd0, c);
        chk("b2b_product", product, 382);

        for (int i = 0; i < 1500; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                op(rx, ry, 1'b0, -1, -1, 1'b1, 8'($urandom),
                   8'($urandom), c);
                op(8'd0, 8'd0, c, -1, -1, 1'b0, 8'd0, 8'd0, c);
            end else begin
                simple(rx, ry);
            end
        end

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
